// File: rtl/dpram_port_arbiter_pkg.sv
// Shared types for the dual-port RAM request arbiter.
// Priority and conflict-type encodings plus default widths.
package dpram_port_arbiter_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  typedef enum logic [1:0] {
    CF_NONE = 2'd0,
    CF_WW   = 2'd1,
    CF_RW   = 2'd2
  } cf_e;

  function automatic cf_e cf_type(
    input logic hit,
    input logic we_a,
    input logic we_b
  );
    if (!hit)             return CF_NONE;
    else if (we_a & we_b) return CF_WW;
    else if (we_a | we_b) return CF_RW;
    else                  return CF_NONE;
  endfunction

endpackage

// File: rtl/dpram_req_slot.sv
// One-entry pending request register for a single master.
// Refills in the same cycle the held request is granted.
import dpram_port_arbiter_pkg::*;

module dpram_req_slot #(
  parameter int DW = DATA_W_DEF,
  parameter int AW = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          grant_i,
  output logic          ready_o,
  output logic          pend_o,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o
);

  logic          pend_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          accept;

  assign ready_o = rst_n & (~pend_q | grant_i);
  assign accept  = valid_i & ready_o;

  always_ff @(posedge clk) begin
    if (!rst_n)       pend_q <= 1'b0;
    else if (accept)  pend_q <= 1'b1;
    else if (grant_i) pend_q <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q   <= we_i;
      addr_q <= addr_i;
      data_q <= wdata_i;
    end
  end

  assign pend_o  = pend_q;
  assign we_o    = we_q;
  assign addr_o  = addr_q;
  assign wdata_o = data_q;

endmodule

// File: rtl/dpram_port_arbiter.sv
// Two-master front end for a dual-port RAM: collision
// detection, round-robin serialisation and read responses.
import dpram_port_arbiter_pkg::*;

module dpram_port_arbiter #(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int RAM_LAT    = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  ram_we_a,
  output logic [ADDR_WIDTH-1:0] ram_addr_a,
  output logic [DATA_WIDTH-1:0] ram_din_a,
  input  logic [DATA_WIDTH-1:0] ram_dout_a,
  output logic                  ram_we_b,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_din_b,
  input  logic [DATA_WIDTH-1:0] ram_dout_b,
  output logic                  conflict_pulse,
  output logic [CNT_WIDTH-1:0]  conflict_cnt
);

  logic pend_a, pend_b, we_a, we_b;
  logic live_a, live_b, grant_a, grant_b;
  logic conflict;
  cf_e  cf;
  prio_e prio_q, prio_d;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [RAM_LAT-1:0]   sha_q, sha_d, shb_q, shb_d;
  logic                 vla_q, vlb_q;
  logic [DATA_WIDTH-1:0] rda_q, rdb_q;

  dpram_req_slot #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_slot_a (
    .clk(clk), .rst_n(rst_n),
    .valid_i(a_req_valid), .we_i(a_req_we),
    .addr_i(a_req_addr), .wdata_i(a_req_wdata),
    .grant_i(grant_a), .ready_o(a_req_ready),
    .pend_o(pend_a), .we_o(we_a),
    .addr_o(ram_addr_a), .wdata_o(ram_din_a)
  );

  dpram_req_slot #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_slot_b (
    .clk(clk), .rst_n(rst_n),
    .valid_i(b_req_valid), .we_i(b_req_we),
    .addr_i(b_req_addr), .wdata_i(b_req_wdata),
    .grant_i(grant_b), .ready_o(b_req_ready),
    .pend_o(pend_b), .we_o(we_b),
    .addr_o(ram_addr_b), .wdata_o(ram_din_b)
  );

  // Slots may hold stale entries until the first reset edge
  assign live_a = pend_a & rst_n;
  assign live_b = pend_b & rst_n;

  assign cf = cf_type(live_a & live_b & (ram_addr_a == ram_addr_b),
                      we_a, we_b);
  assign conflict = (cf != CF_NONE);

  assign grant_a = live_a & (~conflict | (prio_q == PRIO_A));
  assign grant_b = live_b & (~conflict | (prio_q == PRIO_B));

  assign ram_we_a       = grant_a & we_a;
  assign ram_we_b       = grant_b & we_b;
  assign conflict_pulse = conflict;
  assign conflict_cnt   = cnt_q;

  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    sha_d  = (sha_q << 1) | RAM_LAT'(grant_a & ~we_a);
    shb_d  = (shb_q << 1) | RAM_LAT'(grant_b & ~we_b);
    if (conflict) begin
      prio_d = (prio_q == PRIO_A) ? PRIO_B : PRIO_A;
      if (cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= PRIO_A;
      cnt_q  <= '0;
      sha_q  <= '0;
      shb_q  <= '0;
      vla_q  <= 1'b0;
      vlb_q  <= 1'b0;
      rda_q  <= '0;
      rdb_q  <= '0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
      sha_q  <= sha_d;
      shb_q  <= shb_d;
      vla_q  <= sha_q[RAM_LAT-1];
      vlb_q  <= shb_q[RAM_LAT-1];
      rda_q  <= sha_q[RAM_LAT-1] ? ram_dout_a : '0;
      rdb_q  <= shb_q[RAM_LAT-1] ? ram_dout_b : '0;
    end
  end

  assign a_rsp_valid = vla_q & rst_n;
  assign b_rsp_valid = vlb_q & rst_n;
  assign a_rsp_rdata = rst_n ? rda_q : '0;
  assign b_rsp_rdata = rst_n ? rdb_q : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a
// behavioural one-cycle-latency dual-port RAM.
module tb_dpram_port_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req_valid, a_req_ready, a_req_we;
  logic [3:0] a_req_addr;
  logic [7:0] a_req_wdata;
  logic       a_rsp_valid;
  logic [7:0] a_rsp_rdata;
  logic       b_req_valid, b_req_ready, b_req_we;
  logic [3:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid;
  logic [7:0] b_rsp_rdata;
  logic       ram_we_a, ram_we_b;
  logic [3:0] ram_addr_a, ram_addr_b;
  logic [7:0] ram_din_a, ram_din_b;
  logic [7:0] ram_dout_a, ram_dout_b;
  logic       conflict_pulse;
  logic [3:0] conflict_cnt;

  logic [7:0] mem [16];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4),
    .RAM_LAT(1), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
    .a_req_we(a_req_we), .a_req_addr(a_req_addr),
    .a_req_wdata(a_req_wdata),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
    .b_req_we(b_req_we), .b_req_addr(b_req_addr),
    .b_req_wdata(b_req_wdata),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a),
    .ram_din_a(ram_din_a), .ram_dout_a(ram_dout_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b),
    .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b),
    .conflict_pulse(conflict_pulse),
    .conflict_cnt(conflict_cnt)
  );

  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_a <= mem[ram_addr_a];
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic av, input logic aw,
                       input logic [3:0] aa, input logic [7:0] ad,
                       input logic bv, input logic bw,
                       input logic [3:0] ba, input logic [7:0] bd);
    a_req_valid = av; a_req_we = aw;
    a_req_addr  = aa; a_req_wdata = ad;
    b_req_valid = bv; b_req_we = bw;
    b_req_addr  = ba; b_req_wdata = bd;
    step();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b1; a_req_we = 1'b0;
    a_req_addr = 4'h0; a_req_wdata = 8'h00;
    b_req_valid = 1'b0; b_req_we = 1'b0;
    b_req_addr = 4'h0; b_req_wdata = 8'h00;

    repeat (3) step();
    @(negedge clk);
    chk("rst_a_ready", 32'(a_req_ready), 32'd0);
    chk("rst_we_a", 32'(ram_we_a), 32'd0);
    chk("rst_we_b", 32'(ram_we_b), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);
    chk("rst_rsp", 32'(a_rsp_valid), 32'd0);
    step();
    rst_n = 1'b1;
    a_req_valid = 1'b0;
    @(negedge clk);
    chk("rel_a_ready", 32'(a_req_ready), 32'd1);
    chk("rel_b_ready", 32'(b_req_ready), 32'd1);

    // Two writes to different addresses issue together
    issue(1, 1, 4'h3, 8'hA5, 1, 1, 4'h7, 8'h5A);
    @(negedge clk);
    chk("ww_diff_we_a", 32'(ram_we_a), 32'd1);
    chk("ww_diff_we_b", 32'(ram_we_b), 32'd1);
    chk("ww_diff_addr_a", 32'(ram_addr_a), 32'h3);
    chk("ww_diff_din_b", 32'(ram_din_b), 32'h5A);
    chk("ww_diff_cf", 32'(conflict_pulse), 32'd0);
    step();

    issue(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    @(negedge clk);
    chk("rd3_we_a", 32'(ram_we_a), 32'd0);
    step();
    @(negedge clk);
    chk("rd3_early", 32'(a_rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("rd3_vld", 32'(a_rsp_valid), 32'd1);
    chk("rd3_data", 32'(a_rsp_rdata), 32'hA5);
    step();
    @(negedge clk);
    chk("rd3_pulse", 32'(a_rsp_valid), 32'd0);

    // Write/write collision, priority A
    issue(1, 1, 4'h5, 8'hF0, 1, 1, 4'h5, 8'h0F);
    @(negedge clk);
    chk("ww5_cf", 32'(conflict_pulse), 32'd1);
    chk("ww5_we_a", 32'(ram_we_a), 32'd1);
    chk("ww5_we_b", 32'(ram_we_b), 32'd0);
    chk("ww5_b_ready", 32'(b_req_ready), 32'd0);
    step();
    @(negedge clk);
    chk("ww5_we_a2", 32'(ram_we_a), 32'd0);
    chk("ww5_we_b2", 32'(ram_we_b), 32'd1);
    chk("ww5_din_b2", 32'(ram_din_b), 32'h0F);
    chk("ww5_cf2", 32'(conflict_pulse), 32'd0);
    chk("ww5_cnt", 32'(conflict_cnt), 32'd1);
    step();

    issue(1, 0, 4'h5, 8'h00, 1, 0, 4'h5, 8'h00);
    @(negedge clk);
    chk("rr5_cf", 32'(conflict_pulse), 32'd0);
    step();
    step();
    @(negedge clk);
    chk("rr5_a_vld", 32'(a_rsp_valid), 32'd1);
    chk("rr5_b_vld", 32'(b_rsp_valid), 32'd1);
    chk("rr5_a_data", 32'(a_rsp_rdata), 32'h0F);
    chk("rr5_b_data", 32'(b_rsp_rdata), 32'h0F);
    step();

    // Read/write collision, priority now B
    issue(1, 0, 4'h9, 8'h00, 1, 1, 4'h9, 8'h33);
    @(negedge clk);
    chk("rw9_cf", 32'(conflict_pulse), 32'd1);
    chk("rw9_we_b", 32'(ram_we_b), 32'd1);
    chk("rw9_cnt", 32'(conflict_cnt), 32'd1);
    step();
    @(negedge clk);
    chk("rw9_cnt2", 32'(conflict_cnt), 32'd2);
    chk("rw9_cf2", 32'(conflict_pulse), 32'd0);
    step();
    @(negedge clk);
    chk("rw9_early", 32'(a_rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("rw9_vld", 32'(a_rsp_valid), 32'd1);
    chk("rw9_data", 32'(a_rsp_rdata), 32'h33);
    step();

    issue(1, 1, 4'h2, 8'hC3, 0, 0, 4'h0, 8'h00);
    step();
    issue(1, 0, 4'h2, 8'h00, 1, 0, 4'h2, 8'h00);
    @(negedge clk);
    chk("rr2_cf", 32'(conflict_pulse), 32'd0);
    chk("rr2_a_ready", 32'(a_req_ready), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("rr2_a_vld", 32'(a_rsp_valid), 32'd1);
    chk("rr2_b_vld", 32'(b_rsp_valid), 32'd1);
    chk("rr2_a_data", 32'(a_rsp_rdata), 32'hC3);
    chk("rr2_b_data", 32'(b_rsp_rdata), 32'hC3);
    step();

    // Counter starts at 2; 16 more collisions must saturate
    for (int i = 0; i < 16; i++) begin
      issue(1, 1, 4'hE, 8'(i), 1, 1, 4'hE, 8'(~i));
      step();
      if (i == 12) begin
        @(negedge clk);
        chk("sat_reach", 32'(conflict_cnt), 32'hF);
      end
    end
    @(negedge clk);
    chk("sat_hold", 32'(conflict_cnt), 32'hF);

    // Reset with a read in flight squashes its response
    issue(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_rsp", 32'(a_rsp_valid), 32'd0);
    chk("mid_rst_ready", 32'(a_req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_rsp2", 32'(a_rsp_valid), 32'd0);
    chk("mid_rst_cnt", 32'(conflict_cnt), 32'd0);
    step();
    @(negedge clk);
    chk("mid_rst_rsp3", 32'(a_rsp_valid), 32'd0);
    chk("mid_rst_we", 32'(ram_we_a), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
